// File: rtl/spi_link_pkg.sv
// Definitions shared by the SPI link serializer and deserializer: frame geometry,
// link FSM state encoding, opcode values and a constant clog2 helper.
package spi_link_pkg;

   localparam int ADDR_W   = 8;
   localparam int OPCODE_W = 2;
   localparam int SHIFT_W  = ADDR_W + OPCODE_W;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } link_state_t;

   typedef enum logic [1:0] {
      OP_READ  = 2'b00,
      OP_WRITE = 2'b01,
      OP_BURST = 2'b10,
      OP_CTRL  = 2'b11
   } opcode_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Brings spi_clk, n_cs and sdi into the clk domain and flags each spi_clk rising edge.
module spi_edge_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic spi_clk,
   input  logic n_cs,
   input  logic sdi,
   output logic rise,
   output logic n_cs_sync,
   output logic sdi_sync
);

   // sclk_q[1:0] is the synchroniser, sclk_q[2] holds the previous synchronised level
   logic [2:0] sclk_q;
   logic [1:0] cs_q;
   logic [1:0] sdi_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_q <= 3'b000;
         cs_q   <= 2'b11;
         sdi_q  <= 2'b11;
      end else begin
         sclk_q <= {sclk_q[1:0], spi_clk};
         cs_q   <= {cs_q[0], n_cs};
         sdi_q  <= {sdi_q[0], sdi};
      end
   end

   assign rise      = ({sclk_q[2], sclk_q[1]} == 2'b01);
   assign n_cs_sync = cs_q[1];
   assign sdi_sync  = sdi_q[1];

endmodule

// File: rtl/deserializer.sv
// SPI frame receiver: shifts {opcode, addr} frames in and holds each word for a
// valid/ready handshake. Define DESERIALIZER_SKIP_FIRST_EN to drop a leading junk bit per frame.
//
// state    | meaning
// ST_IDLE  | n_cs high, counter and shift register cleared, spi_clk ignored
// ST_SHIFT | n_cs low, sampling sdi on each spi_clk rising edge
module deserializer
   import spi_link_pkg::*;
#(
   parameter int ADDRW   = ADDR_W,
   parameter int OPCODEW = OPCODE_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               n_cs,
   input  logic               spi_clk,
   input  logic               sdi,
   input  logic               ready_in,
   output logic               valid_out,
   output logic [OPCODEW-1:0] opcode,
   output logic [ADDRW-1:0]   addr,
   output logic               err
);

   // Equals the shared SHIFT_W at the default field widths
   localparam int FRAME_W = ADDRW + OPCODEW;
   localparam int CNT_W   = clog2(FRAME_W + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);

   link_state_t        state;
   logic [CNT_W-1:0]   bit_cnt;
   logic [FRAME_W-1:0] shreg;
   logic               rise;
   logic               cs_sync;
   logic               sdi_sync;
`ifdef DESERIALIZER_SKIP_FIRST_EN
   logic               skip;
`endif

   spi_edge_sync u_sync (
      .clk       (clk),
      .rst_n     (rst_n),
      .spi_clk   (spi_clk),
      .n_cs      (n_cs),
      .sdi       (sdi),
      .rise      (rise),
      .n_cs_sync (cs_sync),
      .sdi_sync  (sdi_sync)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         bit_cnt   <= '0;
         shreg     <= '0;
         valid_out <= 1'b0;
         opcode    <= '0;
         addr      <= '0;
         err       <= 1'b0;
`ifdef DESERIALIZER_SKIP_FIRST_EN
         skip      <= 1'b1;
`endif
      end else begin
         err <= 1'b0;
         if (valid_out && ready_in) valid_out <= 1'b0;
         case (state)
            ST_IDLE: begin
               bit_cnt <= '0;
               shreg   <= '0;
`ifdef DESERIALIZER_SKIP_FIRST_EN
               skip    <= 1'b1;
`endif
               if (!cs_sync) state <= ST_SHIFT;
            end
            ST_SHIFT: begin
               // Completion wins over n_cs rising so a full frame is never flagged as an abort
               if (bit_cnt == CNT_FULL) begin
                  bit_cnt <= '0;
                  shreg   <= '0;
`ifdef DESERIALIZER_SKIP_FIRST_EN
                  skip    <= 1'b1;
`endif
                  if (valid_out && !ready_in) begin
                     err <= 1'b1;
                  end else begin
                     opcode    <= shreg[FRAME_W-1 -: OPCODEW];
                     addr      <= shreg[ADDRW-1:0];
                     valid_out <= 1'b1;
                  end
                  if (cs_sync) state <= ST_IDLE;
               end else if (cs_sync) begin
                  state   <= ST_IDLE;
                  bit_cnt <= '0;
                  shreg   <= '0;
                  if (bit_cnt != '0) err <= 1'b1;
               end else if (rise) begin
`ifdef DESERIALIZER_SKIP_FIRST_EN
                  if (skip) begin
                     skip <= 1'b0;
                  end else begin
                     shreg   <= {shreg[FRAME_W-2:0], sdi_sync};
                     bit_cnt <= bit_cnt + CNT_W'(1);
                  end
`else
                  shreg   <= {shreg[FRAME_W-2:0], sdi_sync};
                  bit_cnt <= bit_cnt + CNT_W'(1);
`endif
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/deserializer.md
DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 SHALL have parameter ADDRW, default 8, address field width.
REQ-002 SHALL have parameter OPCODEW, default 2, opcode field width.
REQ-003 SHALL have port clk  input  1  system clock; all state on posedge; f_clk >= 4x f_spi_clk.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port n_cs  input  1  frame select, active-low, asynchronous to clk.
REQ-006 SHALL have port spi_clk  input  1  serial clock, asynchronous to clk.
REQ-007 SHALL have port sdi  input  1  serial data, MSB first, changed by the sender on the spi_clk falling edge.
REQ-008 SHALL have port ready_in  input  1  downstream accepts the held word.
REQ-009 SHALL have port valid_out  output  1  held word valid.
REQ-010 SHALL have port opcode  output  OPCODEW  received opcode, frame bits [SHIFT_W-1 -: OPCODEW].
REQ-011 SHALL have port addr  output  ADDRW  received address, frame bits [ADDRW-1:0].
REQ-012 SHALL have port err  output  1  one-cycle error pulse (abort or overrun).

Function
REQ-013 SHALL synchronise spi_clk, n_cs and sdi through 2-flop chains; n_cs and sdi chains reset to 1, spi_clk chain resets to 0.
REQ-014 SHALL detect an spi_clk rising edge as synchronised history 2'b01 and sample synchronised sdi on that clk cycle only.
REQ-015 SHALL implement FSM IDLE, SHIFT: IDLE->SHIFT on synchronised n_cs low; SHIFT->IDLE on synchronised n_cs high.
REQ-016 SHALL, in SHIFT, left-shift each sample into a SHIFT_W-bit register and increment a bit counter of width clog2(SHIFT_W+1).
REQ-017 SHALL, when the counter reaches SHIFT_W, load opcode/addr from the shift register, set valid_out on the next clk edge, and reset the counter to 0, permitting back-to-back frames under one n_cs low.
REQ-018 SHALL hold opcode, addr and valid_out stable while valid_out=1 and ready_in=0.
REQ-019 SHALL clear valid_out on the clk edge after the cycle in which valid_out=1 and ready_in=1.
REQ-020 SHALL, on frame completion while valid_out=1 and ready_in=0, discard the new frame, keep the held word, and pulse err for one cycle (overrun).
REQ-021 SHALL, on frame completion in the same cycle as a valid_out/ready_in handshake, load the new word with valid_out remaining 1 and no err.
REQ-022 SHALL, on synchronised n_cs rising with counter != 0, pulse err for one cycle, clear the counter and shift register, and leave the held word untouched (abort).
REQ-023 SHALL ignore spi_clk edges and sdi while in IDLE.

Reset
REQ-024 SHALL, while rst_n=0, force state IDLE, counter 0, shift register 0, valid_out 0, opcode 0, addr 0, err 0, independent of clk.
REQ-025 SHALL, on reset assertion mid-frame, discard the partial frame without raising err.

Configuration
REQ-026 SHALL, with DESERIALIZER_SKIP_FIRST_EN defined, discard the first rising-edge sample after entering SHIFT and after each completed frame, so each frame is SHIFT_W+1 samples.
REQ-027 SHALL, without DESERIALIZER_SKIP_FIRST_EN, treat every sample as payload, so each frame is SHIFT_W samples.

Structure
REQ-028 SHALL take the SHIFT_W = ADDRW+OPCODEW constant, the clog2 function, the FSM state encoding and the opcode encodings from shared package spi_link_pkg, which the serializer also uses.
REQ-029 SHALL implement synchroniser plus edge detector as sub-module spi_edge_sync (outputs: rise pulse, synchronised n_cs, synchronised sdi).

Verification
REQ-030 SHALL cover: n_cs low, 10 bits 2'b10 + 8'hA5 shifted in, ready_in=1 -> valid_out 1 cycle, opcode=2'b10, addr=8'hA5, err=0.
REQ-031 SHALL cover: ready_in=0, frame 2'b01/8'h3C then 2'b11/8'hFF -> held 2'b01/8'h3C persists, err pulses once on the second completion.
REQ-032 SHALL cover: n_cs rises after 4 bits -> err pulses 1 cycle, valid_out stays 0; the next full frame 2'b00/8'h01 is received correctly.
REQ-033 SHALL cover: two back-to-back frames under one n_cs low with ready_in=1 -> two valid_out pulses with the correct values in order.
REQ-034 SHALL cover: rst_n low after 6 bits -> all outputs 0 asynchronously, err=0; the next frame after release is received correctly.
REQ-035 SHALL cover: with DESERIALIZER_SKIP_FIRST_EN, a leading junk bit 1 + 2'b10 + 8'h5A -> opcode=2'b10, addr=8'h5A.
